// File: rtl/immediate_generate_pipe.sv
// Pipelined immediate generator for the ID stage.
// Forms the immediate for every format from instruction bits [31:7], widens it
// to XLEN and passes it through STAGES register stages under valid/stall/flush
// control from the hazard unit.
module immediate_generate_pipe #(
    parameter int XLEN   = 32,  // 32 or 64
    parameter int STAGES = 1    // 0, 1 or 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [24:0]     IN,
    input  logic [2:0]      IMM_SEL,
    input  logic            VALID_IN,
    input  logic            STALL,
    input  logic            FLUSH,
    output logic [XLEN-1:0] OUT,
    output logic            VALID_OUT,
    output logic            SHAMT_ERR
);

    localparam logic [2:0] SEL_U          = 3'b000;
    localparam logic [2:0] SEL_J          = 3'b001;
    localparam logic [2:0] SEL_S          = 3'b010;
    localparam logic [2:0] SEL_B          = 3'b011;
    localparam logic [2:0] SEL_I_SIGNED   = 3'b100;
    localparam logic [2:0] SEL_I_SHIFT    = 3'b101;
    localparam logic [2:0] SEL_I_UNSIGNED = 3'b110;
    localparam logic [2:0] SEL_CSR_ZIMM   = 3'b111;

    logic [31:0]     imm32_next;
    logic            sext_next;
    logic            err_next;
    logic [XLEN-1:0] imm_next;

    // Form the 32-bit immediate and note whether it extends with its sign.
    always_comb begin
        imm32_next = '0;
        sext_next  = 1'b0;
        err_next   = 1'b0;
        case (IMM_SEL)
            SEL_U: begin
                imm32_next = {IN[24:5], 12'b0};
                sext_next  = 1'b1;
            end
            SEL_J: begin
                imm32_next = {{11{IN[24]}}, IN[24], IN[12:5], IN[13], IN[23:14], 1'b0};
                sext_next  = 1'b1;
            end
            SEL_S: begin
                imm32_next = {{20{IN[24]}}, IN[24:18], IN[4:0]};
                sext_next  = 1'b1;
            end
            SEL_B: begin
                imm32_next = {{19{IN[24]}}, IN[24], IN[0], IN[23:18], IN[4:1], 1'b0};
                sext_next  = 1'b1;
            end
            SEL_I_SIGNED: begin
                imm32_next = {{20{IN[24]}}, IN[24:13]};
                sext_next  = 1'b1;
            end
            SEL_I_SHIFT: begin
                // RV64 uses a 6-bit shamt; in RV32 the sixth bit is reserved.
                if (XLEN == 64) begin
                    imm32_next = {26'b0, IN[18:13]};
                end else begin
                    imm32_next = {27'b0, IN[17:13]};
                    err_next   = IN[18];
                end
            end
            SEL_I_UNSIGNED: begin
                imm32_next = {20'b0, IN[24:13]};
            end
            SEL_CSR_ZIMM: begin
                imm32_next = {27'b0, IN[12:8]};
            end
            default: begin
                imm32_next = '0;
            end
        endcase
    end

    // Widen to XLEN: fill the upper bits with the sign only for signed formats.
    always_comb begin
        imm_next       = {XLEN{sext_next & imm32_next[31]}};
        imm_next[31:0] = imm32_next;
    end

    // Link index 0 is the formed value; index n+1 is the output of stage n.
    logic [XLEN-1:0] data_link  [STAGES+1];
    logic            valid_link [STAGES+1];
    logic            err_link   [STAGES+1];

    assign data_link[0]  = imm_next;
    assign valid_link[0] = VALID_IN;
    assign err_link[0]   = err_next;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [XLEN-1:0] data_reg;
            logic            valid_reg;
            logic            err_reg;

            // Stage register: reset clears all, flush kills valid, stall holds.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                    err_reg   <= 1'b0;
                end else if (FLUSH) begin
                    valid_reg <= 1'b0;
                end else if (!STALL) begin
                    valid_reg <= valid_link[gi];
                    data_reg  <= data_link[gi];
                    err_reg   <= err_link[gi];
                end
            end

            assign data_link[gi+1]  = data_reg;
            assign valid_link[gi+1] = valid_reg;
            assign err_link[gi+1]   = err_reg;
        end
    endgenerate

    logic live;

    generate
        if (STAGES == 0) begin : g_comb_valid
            assign live = VALID_IN & ~FLUSH & ~RESET;
        end else begin : g_reg_valid
            assign live = valid_link[STAGES];
        end
    endgenerate

    // Dead entries (bubbles, flushed slots) never expose stale data.
    assign VALID_OUT = live;
    assign OUT       = live ? data_link[STAGES] : '0;
    assign SHAMT_ERR = live & err_link[STAGES];

endmodule

// File: tb/tb_immediate_generate_pipe.sv
// Bench for immediate_generate_pipe: three instances (32-bit/1 stage,
// 64-bit/2 stages, 32-bit/0 stages) share one stimulus stream. Expected
// results are queued when driven and retired when each instance is due.
module tb_immediate_generate_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [24:0] in_bus = '0;
    logic [2:0]  sel = '0;
    logic        vin = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic [31:0] o0;
    logic [63:0] o1;
    logic [31:0] o2;
    logic        v0, v1, v2;
    logic        e0, e1, e2;

    always #5 clk = ~clk;

    immediate_generate_pipe #(.XLEN(32), .STAGES(1)) u_x32_s1 (
        .CLK(clk), .RESET(rst), .IN(in_bus), .IMM_SEL(sel), .VALID_IN(vin),
        .STALL(stall), .FLUSH(flush), .OUT(o0), .VALID_OUT(v0), .SHAMT_ERR(e0)
    );

    immediate_generate_pipe #(.XLEN(64), .STAGES(2)) u_x64_s2 (
        .CLK(clk), .RESET(rst), .IN(in_bus), .IMM_SEL(sel), .VALID_IN(vin),
        .STALL(stall), .FLUSH(flush), .OUT(o1), .VALID_OUT(v1), .SHAMT_ERR(e1)
    );

    immediate_generate_pipe #(.XLEN(32), .STAGES(0)) u_x32_s0 (
        .CLK(clk), .RESET(rst), .IN(in_bus), .IMM_SEL(sel), .VALID_IN(vin),
        .STALL(stall), .FLUSH(flush), .OUT(o2), .VALID_OUT(v2), .SHAMT_ERR(e2)
    );

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [31:0] e32;
        logic        err32;
        logic [63:0] e64;
    } vec_t;

    typedef struct {
        logic [63:0] val;
        logic        err;
        int          target;
    } exp_t;

    localparam int NV = 11;
    vec_t vt [NV];

    exp_t        sb [3][$];
    int          adv [3];
    logic        held [3];
    logic        last_v [3];
    logic [63:0] last_o [3];
    logic        last_e [3];
    int          st_of [3];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    task automatic check_inst(input int i, input logic dv, input logic [63:0] dout,
                              input logic derr, input string name);
        logic        ev;
        logic [63:0] eo;
        logic        ee;
        exp_t        e;
        if (held[i]) begin
            ev = last_v[i];
            eo = last_o[i];
            ee = last_e[i];
        end else if (sb[i].size() > 0 && sb[i][0].target <= adv[i]) begin
            e  = sb[i].pop_front();
            ev = 1'b1;
            eo = e.val;
            ee = e.err;
        end else begin
            ev = 1'b0;
            eo = '0;
            ee = 1'b0;
        end
        total++;
        if (dv !== ev || dout !== eo || derr !== ee) begin
            bad++;
            $display("FAIL %s cyc=%0d: got valid=%b out=%h err=%b, want valid=%b out=%h err=%b",
                     name, cyc, dv, dout, derr, ev, eo, ee);
        end else if (ev) begin
            $display("ok   %s cyc=%0d out=%h err=%b", name, cyc, dout, derr);
        end
        last_v[i] = ev;
        last_o[i] = eo;
        last_e[i] = ee;
    endtask

    // One clock cycle: drive just after the rising edge, check on the falling edge.
    task automatic drive_cycle(input logic vld, input vec_t v, input logic stl,
                               input logic fl, input logic rs);
        exp_t e;
        #1;
        rst    = rs;
        vin    = vld;
        stall  = stl;
        flush  = fl;
        in_bus = v.instr[31:7];
        sel    = v.sel;
        for (int i = 0; i < 3; i++) begin
            if (vld && !fl && !rs && (st_of[i] == 0 || !stl)) begin
                e.val    = (i == 1) ? v.e64 : {32'b0, v.e32};
                e.err    = (i == 1) ? 1'b0 : v.err32;
                e.target = adv[i] + st_of[i];
                sb[i].push_back(e);
            end
        end
        @(negedge clk);
        check_inst(0, v0, {32'b0, o0}, e0, "x32s1");
        check_inst(1, v1, o1, e1, "x64s2");
        check_inst(2, v2, {32'b0, o2}, e2, "x32s0");
        if (fl || rs) begin
            for (int i = 0; i < 3; i++) sb[i].delete();
        end
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            held[i] = (st_of[i] != 0) && stl && !fl && !rs;
            if (!held[i]) adv[i]++;
        end
    endtask

    task automatic bubbles(input int n);
        for (int k = 0; k < n; k++) drive_cycle(1'b0, vt[0], 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //           instr         sel     exp32         err  exp64
        vt[0]  = '{32'hFFF00093, 3'b100, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFF_FFFFFFFF};
        vt[1]  = '{32'hFF9FF06F, 3'b001, 32'hFFFFFFF8, 1'b0, 64'hFFFFFFFF_FFFFFFF8};
        vt[2]  = '{32'h123452B7, 3'b000, 32'h12345000, 1'b0, 64'h00000000_12345000};
        vt[3]  = '{32'h300FD073, 3'b111, 32'h0000001F, 1'b0, 64'h00000000_0000001F};
        vt[4]  = '{32'h02109093, 3'b101, 32'h00000001, 1'b1, 64'h00000000_00000021};
        vt[5]  = '{32'hFFF00093, 3'b110, 32'h00000FFF, 1'b0, 64'h00000000_00000FFF};
        vt[6]  = '{32'hFE112E23, 3'b010, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFF_FFFFFFFC};
        vt[7]  = '{32'h00208463, 3'b011, 32'h00000008, 1'b0, 64'h00000000_00000008};
        vt[8]  = '{32'h802080E3, 3'b011, 32'hFFFFF800, 1'b0, 64'hFFFFFFFF_FFFFF800};
        vt[9]  = '{32'h800002B7, 3'b000, 32'h80000000, 1'b0, 64'hFFFFFFFF_80000000};
        vt[10] = '{32'h01F09093, 3'b101, 32'h0000001F, 1'b0, 64'h00000000_0000001F};

        st_of[0] = 1;
        st_of[1] = 2;
        st_of[2] = 0;
        for (int i = 0; i < 3; i++) begin
            adv[i]    = 0;
            held[i]   = 1'b0;
            last_v[i] = 1'b0;
            last_o[i] = '0;
            last_e[i] = 1'b0;
        end

        // Reset with a live input: nothing may appear.
        @(posedge clk);
        drive_cycle(1'b1, vt[0], 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, vt[1], 1'b0, 1'b0, 1'b1);

        // All formats back-to-back.
        for (int k = 0; k < NV; k++) drive_cycle(1'b1, vt[k], 1'b0, 1'b0, 1'b0);
        bubbles(3);

        // Stall for 3 cycles after B enters; order A,B,C preserved.
        drive_cycle(1'b1, vt[0], 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, vt[1], 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, vt[2], 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, vt[3], 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, vt[4], 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, vt[5], 1'b0, 1'b0, 1'b0);
        bubbles(3);

        // Flush together with stall and a live input while entries are in flight.
        drive_cycle(1'b1, vt[6], 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, vt[7], 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, vt[8], 1'b1, 1'b1, 1'b0);
        bubbles(3);

        // Mid-stream reset, then a fresh instruction.
        drive_cycle(1'b1, vt[9], 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, vt[10], 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, vt[0], 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, vt[2], 1'b0, 1'b0, 1'b0);
        bubbles(3);

        // Anything still queued was never produced.
        for (int i = 0; i < 3; i++) begin
            total++;
            if (sb[i].size() != 0) begin
                bad++;
                $display("FAIL drain inst=%0d: got %0d results outstanding, want 0", i, sb[i].size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
